// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared adder helpers: beat count and per-element saturating add
package add_pkg;

    localparam int LANES_DEFAULT     = 16;
    localparam int DIMENTION_DEFAULT = 768;
    localparam int BEATS             = DIMENTION_DEFAULT / LANES_DEFAULT;

    function automatic int calc_beats(input int dimention, input int lanes);
        return dimention / lanes;
    endfunction

    // Sum of two sign-extended elements; clamped to the signed w-bit range when saturating.
    // In wrap mode the caller keeps the low w bits of the result.
    function automatic int sat_add(input int a, input int b, input int w, input bit saturate);
        int s;
        int hi;
        int lo;
        s  = a + b;
        hi = (1 << (w - 1)) - 1;
        lo = -hi - 1;
        if (saturate) begin
            if (s > hi) begin
                s = hi;
            end else if (s < lo) begin
                s = lo;
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/skip_fifo.sv
// rtl/skip_fifo.sv - register-array FIFO with combinational head and synchronous clear
module skip_fifo
    import add_pkg::*;
#(
    parameter int WIDTH_DATA = 128,
    parameter int DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH_DATA-1:0]      wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH_DATA-1:0]      rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [WIDTH_DATA-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      ptr_w_q, ptr_w_d;
    logic [PTR_W-1:0]      ptr_r_q, ptr_r_d;
    logic [PTR_W-1:0]      used;

    // Extra pointer bit distinguishes full from empty when the indices coincide.
    assign used    = ptr_w_q - ptr_r_q;
    assign empty_o = (ptr_w_q == ptr_r_q);
    assign full_o  = (ptr_w_q[PTR_W-1] != ptr_r_q[PTR_W-1]) &&
                     (ptr_w_q[AW-1:0] == ptr_r_q[AW-1:0]);
    assign count_o = ($clog2(DEPTH+1))'(used);
    assign rdata_o = mem_q[ptr_r_q[AW-1:0]];

    always_comb begin
        ptr_w_d = ptr_w_q;
        ptr_r_d = ptr_r_q;
        if (clear_i) begin
            ptr_w_d = '0;
            ptr_r_d = '0;
        end else begin
            if (push_i && !full_o) begin
                ptr_w_d = ptr_w_q + 1'b1;
            end
            if (pop_i && !empty_o) begin
                ptr_r_d = ptr_r_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_w_q <= '0;
            ptr_r_q <= '0;
        end else begin
            ptr_w_q <= ptr_w_d;
            ptr_r_q <= ptr_r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clear_i) begin
            mem_q[ptr_w_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/residual_skip_adder.sv
// rtl/residual_skip_adder.sv - streaming residual adder: skip FIFO plus lane-wise add and output register
module residual_skip_adder
    import add_pkg::*;
#(
    parameter int LANES     = 16,
    parameter int DIMENTION = 768,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 64,
    parameter int SATURATE  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       skip_valid,
    output logic                       skip_ready,
    input  logic [LANES*WIDTH-1:0]     skip_data,
    input  logic                       main_valid,
    output logic                       main_ready,
    input  logic [LANES*WIDTH-1:0]     main_data,
    output logic                       sum_valid,
    input  logic                       sum_ready,
    output logic [LANES*WIDTH-1:0]     sum_data,
    output logic                       sum_last,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int NBEATS = calc_beats(DIMENTION, LANES);
    localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int DW     = LANES * WIDTH;

    logic [DW-1:0]    head;
    logic [DW-1:0]    lane_sum;
    logic             fifo_full;
    logic             fifo_empty;
    logic             out_free;
    logic             push;
    logic             fire;
    logic             cnt_at_last;

    logic             sum_valid_q, sum_valid_d;
    logic [DW-1:0]    sum_data_q,  sum_data_d;
    logic             sum_last_q,  sum_last_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    // Readies are forced low while reset is held so nothing is accepted mid-reset.
    assign out_free   = !sum_valid_q || sum_ready;
    assign skip_ready = rst_n && !fifo_full && !flush;
    assign main_ready = rst_n && !fifo_empty && out_free && !flush;
    assign push       = skip_valid && skip_ready;
    assign fire       = main_valid && main_ready;

    skip_fifo #(
        .WIDTH_DATA (DW),
        .DEPTH      (DEPTH)
    ) u_skip_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush),
        .push_i  (push),
        .wdata_i (skip_data),
        .pop_i   (fire),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_sum[k*WIDTH +: WIDTH] = WIDTH'(sat_add(
            int'($signed(head[k*WIDTH +: WIDTH])),
            int'($signed(main_data[k*WIDTH +: WIDTH])),
            WIDTH, SATURATE != 0));
    end

    assign cnt_at_last = (cnt_q == CNT_W'(NBEATS - 1));

    always_comb begin
        sum_valid_d = sum_valid_q;
        sum_data_d  = sum_data_q;
        sum_last_d  = sum_last_q;
        cnt_d       = cnt_q;
        if (flush) begin
            sum_valid_d = 1'b0;
            sum_data_d  = '0;
            sum_last_d  = 1'b0;
            cnt_d       = '0;
        end else if (fire) begin
            sum_valid_d = 1'b1;
            sum_data_d  = lane_sum;
            sum_last_d  = cnt_at_last;
            cnt_d       = cnt_at_last ? '0 : cnt_q + 1'b1;
        end else if (sum_ready) begin
            sum_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid_q <= 1'b0;
            sum_data_q  <= '0;
            sum_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sum_valid_q <= sum_valid_d;
            sum_data_q  <= sum_data_d;
            sum_last_q  <= sum_last_d;
            cnt_q       <= cnt_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_last  = sum_last_q;

endmodule
